// File: rtl/blur_pkg.sv
// Shared types and constants for the blur pipeline front end.
package blur_pkg;

  localparam int HCOUNT_W     = 11;
  localparam int VCOUNT_W     = 10;
  localparam int HRES_DEFAULT = 1280;
  localparam int VRES_DEFAULT = 720;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/flush_pixel_gen.sv
// Produces the dummy-pixel coordinates that drain the blur line buffer after
// a frame: hcount 0..HRES-1 on rows VRES..VRES+FLUSH_LINES-1, one per cycle.
module flush_pixel_gen
  import blur_pkg::*;
#(
  parameter int HRES        = HRES_DEFAULT,
  parameter int VRES        = VRES_DEFAULT,
  parameter int FLUSH_LINES = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  output logic                valid_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                last_out
);

  localparam logic [HCOUNT_W-1:0] H_LAST  = HCOUNT_W'(HRES - 1);
  localparam logic [VCOUNT_W-1:0] V_FIRST = VCOUNT_W'(VRES);
  localparam logic [VCOUNT_W-1:0] V_LAST  = VCOUNT_W'(VRES + FLUSH_LINES - 1);

  logic                active_q, active_d;
  logic [HCOUNT_W-1:0] h_q, h_d;
  logic [VCOUNT_W-1:0] v_q, v_d;
  logic                last;

  assign last = active_q && (h_q == H_LAST) && (v_q == V_LAST);

  always_comb begin
    active_d = active_q;
    h_d      = h_q;
    v_d      = v_q;
    if (start_in) begin
      active_d = 1'b1;
      h_d      = '0;
      v_d      = V_FIRST;
    end else if (active_q) begin
      if (last) begin
        active_d = 1'b0;
        h_d      = '0;
        v_d      = V_FIRST;
      end else if (h_q == H_LAST) begin
        h_d = '0;
        v_d = v_q + VCOUNT_W'(1);
      end else begin
        h_d = h_q + HCOUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      active_q <= 1'b0;
      h_q      <= '0;
      v_q      <= V_FIRST;
    end else begin
      active_q <= active_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  assign valid_out  = active_q;
  assign hcount_out = h_q;
  assign vcount_out = v_q;
  assign last_out   = last;

endmodule

// File: rtl/blur_frame_sequencer.sv
// Forwards one camera frame at a time into blur_filter, then stalls upstream
// and injects flush lines. Optional drop counter: BLUR_SEQ_DROP_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for an enabled (0,0) pixel; everything else is discarded
// STREAM | forwarding pixels; (0,0) here is a sync error / frame restart
// FLUSH  | upstream stalled, zero pixels on rows VRES.. drain the line buffer
// DONE   | one cycle: frame_done pulse and frame count increment
module blur_frame_sequencer
  import blur_pkg::*;
#(
  parameter int HRES        = HRES_DEFAULT,
  parameter int VRES        = VRES_DEFAULT,
  parameter int FLUSH_LINES = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic                data_valid_in,
  input  logic [15:0]         pixel_data_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic                ready_out,
  output logic                data_valid_out,
  output logic [15:0]         pixel_data_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                flushing_out,
  output logic                frame_done_out,
  output logic [15:0]         frame_count_out,
`ifdef BLUR_SEQ_DROP_CNT_EN
  output logic [15:0]         drop_count_out,
`endif
  output logic                sync_err_out
);

  if (FLUSH_LINES < 1 || FLUSH_LINES > 3) begin : g_flush_lines_chk
    $error("blur_frame_sequencer: FLUSH_LINES must be 1..3");
  end
  if (VRES + FLUSH_LINES - 1 > (1 << VCOUNT_W) - 1) begin : g_vcount_w_chk
    $error("blur_frame_sequencer: vcount width cannot hold VRES+FLUSH_LINES-1");
  end
  if (HRES - 1 > (1 << HCOUNT_W) - 1) begin : g_hcount_w_chk
    $error("blur_frame_sequencer: hcount width cannot hold HRES-1");
  end

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(HRES - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(VRES - 1);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  pixel_t              pix_q, pix_d;
  logic [HCOUNT_W-1:0] hc_q, hc_d;
  logic [VCOUNT_W-1:0] vc_q, vc_d;
  logic                flushing_q, flushing_d;
  logic                done_q, done_d;
  logic [15:0]         count_q, count_d;
  logic                sync_err_q, sync_err_d;

  logic                is_first, is_last, accept, flush_start;
  logic                gen_valid, gen_last;
  logic [HCOUNT_W-1:0] gen_h;
  logic [VCOUNT_W-1:0] gen_v;

  flush_pixel_gen #(
    .HRES        (HRES),
    .VRES        (VRES),
    .FLUSH_LINES (FLUSH_LINES)
  ) u_flush_gen (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (flush_start),
    .valid_out  (gen_valid),
    .hcount_out (gen_h),
    .vcount_out (gen_v),
    .last_out   (gen_last)
  );

  assign is_first = (hcount_in == '0) && (vcount_in == '0);
  assign is_last  = (hcount_in == H_LAST) && (vcount_in == V_LAST);

  // ready_q is zero in FLUSH/DONE, so those states never accept.
  assign accept = data_valid_in && ready_q &&
                  ((state_q == STREAM) || ((state_q == IDLE) && enable_in && is_first));

  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    pix_d       = pix_q;
    hc_d        = hc_q;
    vc_d        = vc_q;
    flushing_d  = 1'b0;
    done_d      = 1'b0;
    count_d     = count_q;
    sync_err_d  = sync_err_q;
    flush_start = 1'b0;

    if (accept) begin
      valid_d = 1'b1;
      pix_d   = pixel_data_in;
      hc_d    = hcount_in;
      vc_d    = vcount_in;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = is_last ? FLUSH : STREAM;
          flush_start = is_last;
        end
      end
      STREAM: begin
        if (accept) begin
          if (is_last) begin
            state_d     = FLUSH;
            flush_start = 1'b1;
          end else if (is_first) begin
            sync_err_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        valid_d    = gen_valid;
        pix_d      = '0;
        hc_d       = gen_h;
        vc_d       = gen_v;
        flushing_d = gen_valid;
        if (gen_last) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        count_d = count_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == STREAM);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      pix_q      <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
      flushing_q <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      pix_q      <= pix_d;
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      flushing_q <= flushing_d;
      done_q     <= done_d;
      count_q    <= count_d;
      sync_err_q <= sync_err_d;
    end
  end

`ifdef BLUR_SEQ_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (data_valid_in && !accept && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count_out = drop_q;
`endif

  assign ready_out       = ready_q;
  assign data_valid_out  = valid_q;
  assign pixel_data_out  = pix_q;
  assign hcount_out      = hc_q;
  assign vcount_out      = vc_q;
  assign flushing_out    = flushing_q;
  assign frame_done_out  = done_q;
  assign frame_count_out = count_q;
  assign sync_err_out    = sync_err_q;

endmodule

// File: doc/blur_frame_sequencer.md
# blur_frame_sequencer

Frame-level controller in front of `blur_filter` on the peripheral FPGA. Forwards one camera frame at a time into the blur pipeline. After each frame's last pixel, it stalls upstream and injects flush lines so the line buffer drains the final rows. Also reports frame completion, frame count and stream-sync errors.

## Interface
Parameters:
- HRES, 1280, active pixels per line
- VRES, 720, active lines per frame
- FLUSH_LINES, 1, dummy lines injected after each frame (1..3)

Ports:
- clk_in  in  1  system clock; the block uses one clock
- rst_in  in  1  reset, asynchronous, active-high
- enable_in  in  1  arm the block to start a new frame; sampled only in IDLE
- data_valid_in  in  1  upstream pixel valid
- pixel_data_in  in  16  RGB565 pixel
- hcount_in  in  11  pixel column
- vcount_in  in  10  pixel row
- ready_out  out  1  upstream may present pixels; any pixel offered while 0 is dropped
- data_valid_out  out  1  pixel valid to `blur_filter`
- pixel_data_out  out  16  forwarded pixel, or 0 during flush
- hcount_out  out  11  column to `blur_filter`
- vcount_out  out  10  row to `blur_filter`
- flushing_out  out  1  high while flush pixels are on the outputs
- frame_done_out  out  1  one-cycle pulse when a frame plus its flush has completed
- frame_count_out  out  16  completed frames; wraps at 2^16
- sync_err_out  out  1  sticky; set on a mid-frame restart; cleared only by reset

## Operation
States:
- **IDLE**
  - Accept a pixel only if enable_in=1, data_valid_in=1 and hcount_in=0, vcount_in=0.
  - That pixel is forwarded and the state moves to STREAM.
  - Any other pixel is discarded.
- **STREAM**
  - Every valid pixel is forwarded unchanged (data, hcount, vcount).
  - Pixel (HRES-1, VRES-1) accepted → FLUSH.
  - Pixel (0,0) accepted → set sync_err_out, forward it as a new frame start, stay in STREAM. No flush occurs and frame_count_out does not change.
- **FLUSH**
  - ready_out=0.
  - Emit HRES·FLUSH_LINES pixels, one per cycle, with data_valid_out=1 and pixel_data_out=0.
  - hcount_out runs 0..HRES-1; vcount_out runs VRES..VRES+FLUSH_LINES-1.
  - After the last flush pixel → DONE.
- **DONE** (one cycle)
  - frame_done_out=1 and frame_count_out increments.
  - Next state is IDLE.

Rules:
- enable_in deasserted mid-frame has no effect; the current frame and its flush complete.
- Out-of-order coordinates other than (0,0) are forwarded unchecked.
- The vcount width must hold VRES+FLUSH_LINES-1; a violation is a compile-time error.

## Timing
- All outputs are registered.
- Forwarding latency: exactly 1 cycle from input acceptance to the outputs.
- Reset values: state IDLE; ready_out 0; data_valid_out 0; pixel/hcount/vcount 0; flushing_out 0; frame_done_out 0; frame_count_out 0; sync_err_out 0.
- ready_out rises on the first clock edge after rst_in deasserts.
- Frame end, with the last pixel accepted at cycle t:
  - that pixel is output at t+1, and ready_out=0 from t+1;
  - flush pixels are output at t+2 .. t+1+N, where N = HRES·FLUSH_LINES, with flushing_out high on exactly those cycles;
  - frame_done_out and ready_out=1 occur at t+2+N.
- Reset asserted mid-frame or mid-flush: all outputs return to reset values immediately, no partial flush is emitted, and the counters clear.

## Configuration
- BLUR_SEQ_DROP_CNT_EN defined:
  - adds the output port drop_count_out (16 bits, saturating at 0xFFFF, reset 0);
  - counts every cycle with data_valid_in=1 whose pixel is not accepted, i.e. IDLE discards and pixels offered while ready_out=0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `blur_pkg`:
  - state enum (IDLE, STREAM, FLUSH, DONE);
  - pixel typedef (16-bit RGB565);
  - default HRES/VRES constants;
  - HCOUNT_W=11 and VCOUNT_W=10.
- One sub-module, `flush_pixel_gen`:
  - started by a one-cycle start pulse;
  - generates the flush hcount/vcount sequence;
  - asserts a last flag on the final flush pixel.

## Test plan
Bench parameters: HRES=8, VRES=4, FLUSH_LINES=1.
- Reset release, then enable_in=1 and a full 32-pixel frame streamed → 32 pixels out with 1-cycle latency; then 8 flush pixels (data 0, vcount 4, hcount 0..7); frame_done_out pulses once; frame_count_out=1; ready_out low for exactly 9 cycles.
- Pixels offered during flush with BLUR_SEQ_DROP_CNT_EN defined → none forwarded; drop_count_out equals the number offered.
- IDLE with enable_in=1 and the stream starting at (3,2) → pixels discarded until (0,0); the frame then proceeds normally.
- (0,0) injected at pixel 17 of a frame → sync_err_out=1 and stays 1; no flush; the subsequent full frame completes and frame_count_out=1.
- enable_in dropped at pixel 5 → the frame and its flush still complete; the next frame is ignored and held in IDLE.
- rst_in asserted at flush pixel 3 → outputs go to 0 asynchronously; frame_count_out=0; after release, a clean frame completes normally.
